// File: rtl/tx_scheduler.sv
// tx_scheduler: shares one serial transmitter between a buffered echo stream
// (4-entry FIFO) and an unbuffered playback stream. Characters are granted
// round-robin, launched with a one-cycle tx_start, and followed by a
// guaranteed idle gap once the transmitter reports completion.
module tx_scheduler #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       echo_valid,
  input  logic [7:0] echo_data,
  output logic       echo_ready,
  input  logic       play_valid,
  input  logic [7:0] play_data,
  output logic       play_ready,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       busy,
  output logic       grant_src,
  output logic       timeout_err,
  output logic [2:0] fifo_count
);

  localparam int FIFO_DEPTH = 4;
  localparam logic [2:0] FIFO_FULL = 3'd4;

  // One counter serves both the completion timeout and the gap, so it is
  // sized for the larger of the two waits and never wraps inside a wait.
  // TIMEOUT_CYCLES is expected to be at least 1.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic             NO_GAP   = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_DONE = 2'd1,
    ST_GAP       = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_tx_data;
  logic             r_tx_start;
  logic             r_grant_src;
  logic             r_timeout_err;

  logic [7:0]       r_fifo_mem [FIFO_DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [2:0]       r_count;

  logic             w_fifo_req;
  logic             w_done_now;
  logic             w_grant_window;
  logic             w_grant_echo;
  logic             w_grant_play;
  logic             w_push;
  logic             w_pop;

  // Readiness comes from the occupancy at the start of the cycle, so a push
  // into a full FIFO is refused even if a pop happens in the same cycle.
  assign echo_ready = (r_count < FIFO_FULL);
  assign w_push     = echo_valid && echo_ready;
  assign w_pop      = w_grant_echo;

  // Decide whether a grant may happen this cycle and which source wins.
  always_comb begin
    w_fifo_req     = (r_count != 3'd0);
    w_done_now     = (r_state == ST_WAIT_DONE) && tx_done;
    w_grant_echo   = 1'b0;
    w_grant_play   = 1'b0;
    // With no gap, the completion cycle itself behaves as an idle cycle so
    // the next character can start right after tx_done.
    if (reset) begin
      w_grant_window = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_grant_window = 1'b1;
    end else if (NO_GAP) begin
      w_grant_window = w_done_now;
    end else begin
      w_grant_window = 1'b0;
    end
    if (w_grant_window) begin
      if (w_fifo_req && play_valid) begin
        // Both requesting: serve whichever source was not served last.
        w_grant_echo = r_grant_src;
        w_grant_play = ~r_grant_src;
      end else begin
        w_grant_echo = w_fifo_req;
        w_grant_play = play_valid;
      end
    end else begin
      w_grant_echo = 1'b0;
      w_grant_play = 1'b0;
    end
  end

  assign play_ready  = w_grant_play;
  // A start strobe left over from a grant is suppressed while reset is high.
  assign tx_start    = r_tx_start && !reset;
  assign tx_data     = r_tx_data;
  assign grant_src   = r_grant_src;
  assign timeout_err = r_timeout_err;
  assign busy        = (r_state != ST_IDLE);
  assign fifo_count  = r_count;

  // Echo FIFO storage; contents need no reset because occupancy gates reads.
  always_ff @(posedge sysclk) begin
    if (w_push && !reset) begin
      r_fifo_mem[r_wr_ptr] <= echo_data;
    end else begin
      r_fifo_mem[r_wr_ptr] <= r_fifo_mem[r_wr_ptr];
    end
  end

  // Echo FIFO pointers and occupancy.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 2'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 2'd1;
      end else begin
        r_rd_ptr <= r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Scheduler state machine: grant, wait for completion or timeout, then gap.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_tx_data     <= 8'd0;
      r_tx_start    <= 1'b0;
      r_grant_src   <= 1'b1;
      r_timeout_err <= 1'b0;
    end else begin
      r_tx_start <= 1'b0;
      if (w_grant_echo || w_grant_play) begin
        r_state     <= ST_WAIT_DONE;
        r_cnt       <= '0;
        r_tx_start  <= 1'b1;
        r_grant_src <= w_grant_play;
        r_tx_data   <= w_grant_play ? play_data : r_fifo_mem[r_rd_ptr];
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
          ST_WAIT_DONE: begin
            if (tx_done) begin
              r_cnt   <= '0;
              r_state <= NO_GAP ? ST_IDLE : ST_GAP;
            end else if (r_cnt == TO_LAST) begin
              r_timeout_err <= 1'b1;
              r_cnt         <= '0;
              r_state       <= NO_GAP ? ST_IDLE : ST_GAP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ST_GAP: begin
            if (r_cnt == GAP_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tx_scheduler.sv
// tb_tx_scheduler: two scheduler instances (16-cycle gap / no gap) driven by
// random echo, playback and transmitter traffic, compared against a
// queue-based reference model through a tx_start scoreboard.
module tb_tx_scheduler;

  localparam int NCYC = 6000;

  logic sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  int cyc = 0;
  always @(posedge sysclk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       s;
    int         c;
  } exp_t;

  task automatic chk(input string name, input int lane, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL lane%0d %s: got 0x%0h expected 0x%0h at cycle %0d", lane, name, act, req, cyc);
    end
  endtask

  for (genvar L = 0; L < 2; L++) begin : g_lane
    localparam int G  = (L == 0) ? 16 : 0;
    localparam int TO = (L == 0) ? 50 : 30;

    logic       reset, echo_valid, echo_ready, play_valid, play_ready;
    logic       tx_start, tx_done, busy, grant_src, timeout_err;
    logic [7:0] echo_data, play_data, tx_data;
    logic [2:0] fifo_count;

    tx_scheduler #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(TO)) u_dut (
      .sysclk      (sysclk),
      .reset       (reset),
      .echo_valid  (echo_valid),
      .echo_data   (echo_data),
      .echo_ready  (echo_ready),
      .play_valid  (play_valid),
      .play_data   (play_data),
      .play_ready  (play_ready),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_done     (tx_done),
      .busy        (busy),
      .grant_src   (grant_src),
      .timeout_err (timeout_err),
      .fifo_count  (fifo_count)
    );

    // Scoreboard of expected transmitter starts, plus reference model state.
    exp_t       expq[$];
    logic [7:0] mq[$];
    bit         m_ok = 1'b0;
    bit         m_wait = 1'b0;
    bit         m_last = 1'b1;
    bit         m_err = 1'b0;
    int         m_start = 0;
    int         m_idle_from = 0;
    logic [7:0] m_txd = 8'd0;
    bit         st_seen = 1'b0;
    bit         pr_seen = 1'b0;

    // What the transmitter and playback requester observe each cycle.
    always @(negedge sysclk) begin
      st_seen <= tx_start;
      pr_seen <= play_ready;
    end

    // Reference model: one step per cycle from the inputs of that cycle.
    always @(negedge sysclk) begin : model
      int         sz;
      bit         idle_now, done_now, can, src, gp;
      logic [7:0] d;
      if (reset) begin
        chk("play_ready_in_reset", L, 32'(play_ready), 32'd0);
        chk("tx_start_in_reset", L, 32'(tx_start), 32'd0);
        mq.delete();
        m_wait = 1'b0; m_idle_from = 0; m_last = 1'b1; m_err = 1'b0; m_txd = 8'd0; m_ok = 1'b1;
        while (expq.size() > 0 && expq[expq.size()-1].c >= cyc) void'(expq.pop_back());
      end else if (m_ok) begin
        idle_now = !m_wait && (cyc >= m_idle_from);
        chk("busy", L, 32'(busy), 32'(!idle_now));
        chk("fifo_count", L, 32'(fifo_count), 32'(mq.size()));
        chk("echo_ready", L, 32'(echo_ready), 32'(mq.size() < 4));
        chk("timeout_err", L, 32'(timeout_err), 32'(m_err));
        chk("tx_data_hold", L, 32'(tx_data), 32'(m_txd));
        chk("grant_src_hold", L, 32'(grant_src), 32'(m_last));
        done_now = 1'b0;
        if (m_wait) begin
          if (tx_done) begin
            m_wait = 1'b0; done_now = 1'b1; m_idle_from = cyc + 1 + G;
          end else if (cyc == m_start + TO - 1) begin
            m_wait = 1'b0; m_err = 1'b1; m_idle_from = cyc + 1 + G;
          end
        end
        can = idle_now || (G == 0 && done_now);
        sz  = mq.size();
        gp  = 1'b0;
        if (can && (sz > 0 || play_valid)) begin
          if (sz > 0 && play_valid) src = !m_last;
          else src = (sz == 0);
          if (!src) d = mq.pop_front();
          else begin d = play_data; gp = 1'b1; end
          m_last = src; m_txd = d; m_wait = 1'b1; m_start = cyc + 1;
          expq.push_back('{d: d, s: src, c: cyc + 1});
        end
        chk("play_ready", L, 32'(play_ready), 32'(gp));
        if (echo_valid && sz < 4) mq.push_back(echo_data);
      end
    end

    // Monitor: every tx_start must match the next scoreboard entry exactly.
    always @(negedge sysclk) begin : monitor
      exp_t e;
      bit   exp_start;
      if (!reset && m_ok) begin
        exp_start = (expq.size() > 0) && (expq[0].c == cyc);
        chk("tx_start", L, 32'(tx_start), 32'(exp_start));
        if (exp_start) begin
          e = expq.pop_front();
          if (tx_start) begin
            chk("tx_data", L, 32'(tx_data), 32'(e.d));
            chk("grant_src", L, 32'(grant_src), 32'(e.s));
          end
        end
        while (expq.size() > 0 && expq[0].c < cyc) void'(expq.pop_front());
      end
    end

    // Stimulus: echo bursts, then contention with playback, then late or
    // missing completions and reset pulses.
    initial begin : driver
      int done_cnt;
      int pe;
      bit play_on, c_phase;
      done_cnt = 0;
      reset = 1'b1; echo_valid = 1'b0; echo_data = 8'd0;
      play_valid = 1'b0; play_data = 8'd0; tx_done = 1'b0;
      for (int k = 0; k < NCYC; k++) begin
        @(posedge sysclk); #1;
        pe      = (k < 2000) ? 50 : ((k < 4000) ? 35 : 25);
        play_on = (k >= 2000);
        c_phase = (k >= 4000);
        reset   = (k < 3) || (k == 1000) || (k == 4500) ||
                  (c_phase && ($urandom_range(0, 299) == 0));
        if (st_seen) begin
          if (c_phase && ($urandom_range(0, 4) == 0)) done_cnt = int'($urandom_range(TO + 1, TO + 40));
          else done_cnt = int'($urandom_range(1, 25));
        end
        tx_done = (done_cnt == 1);
        if (done_cnt > 0) done_cnt--;
        echo_valid = ($urandom_range(0, 99) < pe);
        echo_data  = 8'($urandom);
        if (pr_seen) play_valid = 1'b0;
        if (!play_valid && play_on && ($urandom_range(0, 99) < 30)) begin
          play_valid = 1'b1;
          play_data  = 8'($urandom);
        end
      end
      @(posedge sysclk); #1;
      reset = 1'b0; echo_valid = 1'b0; play_valid = 1'b0; tx_done = 1'b0;
    end
  end

  // Let both lanes drain their last timeout and gap, then report.
  initial begin
    repeat (NCYC + 300) @(posedge sysclk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
